// File: rtl/exc_int_sequencer_if.sv
// Bundles the M-stage, CP0 and IFU signals seen by exc_int_sequencer.
// The master side is the pipeline/CP0; the slave side is the sequencer.
`timescale 1ns/1ps
interface exc_int_sequencer_if;
  logic [5:0]  hw_int;
  logic [5:0]  im;
  logic        ie;
  logic        exl;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_exc;
  logic [4:0]  m_exccode;
  logic        m_eret;
  logic [31:0] epc;
  logic [5:0]  ip_pending;
  logic        flush;
  logic        cp0_enter;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic        cp0_exl_clr;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output hw_int, im, ie, exl, m_valid, m_pc, m_bd, m_exc, m_exccode, m_eret, epc,
    input  ip_pending, flush, cp0_enter, cp0_exccode, cp0_epc, cp0_bd, cp0_exl_clr,
           pc_redirect, redirect_pc, busy
  );

  modport slave (
    input  hw_int, im, ie, exl, m_valid, m_pc, m_bd, m_exc, m_exccode, m_eret, epc,
    output ip_pending, flush, cp0_enter, cp0_exccode, cp0_epc, cp0_bd, cp0_exl_clr,
           pc_redirect, redirect_pc, busy
  );
endinterface

// File: rtl/exc_int_sequencer.sv
// Exception/interrupt entry and ERET exit sequencer for the M stage and CP0.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser on hw_int (2-cycle sample latency).
`timescale 1ns/1ps
module exc_int_sequencer #(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  exc_int_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_DRAIN,
    ST_ERET
  } state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q;

  logic        int_ok, exc_ok, eret_ok;
  logic [31:0] pc_aligned, epc_calc;

  logic        flush_c, enter_c, exl_clr_c, redirect_c;
  logic [31:0] redirect_pc_c;

`ifdef IRQ_SYNC_EN
  logic [5:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      ip_q   <= '0;
    end else begin
      sync_q <= bus.hw_int;
      ip_q   <= sync_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_q <= '0;
    end else begin
      ip_q <= bus.hw_int;
    end
  end
`endif

  assign int_ok  = (|(ip_q & bus.im)) & bus.ie & ~bus.exl & bus.m_valid;
  assign exc_ok  = bus.m_exc & bus.m_valid;
  assign eret_ok = bus.m_eret & bus.m_valid;

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign pc_aligned = bus.m_pc & ~32'd3;
  assign epc_calc   = bus.m_bd ? (pc_aligned - 32'd4) : pc_aligned;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    epc_d         = epc_q;
    bd_d          = bd_q;
    flush_c       = 1'b0;
    enter_c       = 1'b0;
    exl_clr_c     = 1'b0;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;

    case (state_q)
      ST_IDLE: begin
        // Interrupt outranks a same-cycle exception; the killed instruction re-executes.
        if (!reset) begin
          if (int_ok) begin
            flush_c = 1'b1;
            state_d = ST_ENTER;
            code_d  = 5'd0;
            bd_d    = bus.m_bd;
            epc_d   = epc_calc;
          end else if (exc_ok) begin
            flush_c = 1'b1;
            state_d = ST_ENTER;
            code_d  = bus.m_exccode;
            bd_d    = bus.m_bd;
            epc_d   = epc_calc;
          end else if (eret_ok) begin
            flush_c = 1'b1;
            state_d = ST_ERET;
          end
        end
      end
      ST_ENTER: begin
        enter_c       = 1'b1;
        redirect_c    = 1'b1;
        redirect_pc_c = HANDLER_PC;
        flush_c       = 1'b1;
        state_d       = ST_DRAIN;
        cnt_d         = DRAIN_INIT;
      end
      ST_DRAIN: begin
        flush_c = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERET: begin
        exl_clr_c     = 1'b1;
        redirect_c    = 1'b1;
        redirect_pc_c = bus.epc;
        flush_c       = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      epc_q   <= '0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      bd_q    <= bd_d;
    end
  end

  assign bus.ip_pending  = ip_q;
  assign bus.flush       = flush_c;
  assign bus.cp0_enter   = enter_c;
  assign bus.cp0_exccode = code_q;
  assign bus.cp0_epc     = epc_q;
  assign bus.cp0_bd      = bd_q;
  assign bus.cp0_exl_clr = exl_clr_c;
  assign bus.pc_redirect = redirect_c;
  assign bus.redirect_pc = redirect_pc_c;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_int_sequencer.sv
// Directed bench for exc_int_sequencer: entry, priority, bubbles, ERET and reset abort.
`timescale 1ns/1ps
module tb_exc_int_sequencer;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exc_int_sequencer_if bus ();

  exc_int_sequencer #(
    .HANDLER_PC  (32'h0000_4180),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1ns after the edge; outputs are checked 2ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.hw_int    = '0;
    bus.im        = '0;
    bus.ie        = 1'b0;
    bus.exl       = 1'b0;
    bus.m_valid   = 1'b0;
    bus.m_pc      = '0;
    bus.m_bd      = 1'b0;
    bus.m_exc     = 1'b0;
    bus.m_exccode = '0;
    bus.m_eret    = 1'b0;
    bus.epc       = '0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      cyc();
      settle();
    end
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    settle();
    check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_enter", {31'd0, bus.cp0_enter}, 32'd0);
    check("rst_ip",    {26'd0, bus.ip_pending}, 32'd0);
    check("rst_rdpc",  bus.redirect_pc, 32'd0);
    $display("reset state checked");
    reset = 1'b0;

    // Interrupt entry
    cyc();
    bus.hw_int = 6'b000100; bus.im = 6'b000100; bus.ie = 1'b1;
    bus.m_valid = 1'b1; bus.m_pc = 32'h3010;
    settle();
    check("t1_flush_T", {31'd0, bus.flush}, 32'd0);
    for (int i = 1; i < LAT; i++) begin
      cyc(); settle();
      check("t1_flush_sync", {31'd0, bus.flush}, 32'd0);
    end
    cyc(); settle();
    check("t1_flush_T1", {31'd0, bus.flush}, 32'd1);
    check("t1_ip",       {26'd0, bus.ip_pending}, 32'h4);
    check("t1_busy_T1",  {31'd0, bus.busy}, 32'd0);
    bus.hw_int = '0;
    cyc(); settle();
    check("t1_enter", {31'd0, bus.cp0_enter}, 32'd1);
    check("t1_code",  {27'd0, bus.cp0_exccode}, 32'd0);
    check("t1_epc",   bus.cp0_epc, 32'h3010);
    check("t1_rdpc",  bus.redirect_pc, 32'h4180);
    check("t1_redir", {31'd0, bus.pc_redirect}, 32'd1);
    cyc(); settle();
    check("t1_enter_once", {31'd0, bus.cp0_enter}, 32'd0);
    check("t1_drain1",     {31'd0, bus.flush}, 32'd1);
    cyc(); settle();
    check("t1_drain2", {31'd0, bus.flush}, 32'd1);
    cyc(); settle();
    check("t1_flush_end", {31'd0, bus.flush}, 32'd0);
    check("t1_busy_end",  {31'd0, bus.busy}, 32'd0);
    $display("interrupt entry sequence checked");

    // Synchronous exception in a delay slot
    cyc();
    bus.m_exc = 1'b1; bus.m_exccode = 5'd10; bus.m_pc = 32'h3024; bus.m_bd = 1'b1;
    settle();
    check("t2_flush_acc", {31'd0, bus.flush}, 32'd1);
    cyc();
    bus.m_exc = 1'b0; bus.m_bd = 1'b0;
    settle();
    check("t2_enter", {31'd0, bus.cp0_enter}, 32'd1);
    check("t2_code",  {27'd0, bus.cp0_exccode}, 32'd10);
    check("t2_bd",    {31'd0, bus.cp0_bd}, 32'd1);
    check("t2_epc",   bus.cp0_epc, 32'h3020);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(); settle();
      if (!bus.flush) break;
      n++;
    end
    check("t2_flush_len", n, 32'd3);
    check("t2_busy_end", {31'd0, bus.busy}, 32'd0);
    $display("delay-slot exception checked");

    // Interrupt and exception in the same cycle
    cyc();
    bus.m_valid = 1'b0; bus.hw_int = 6'b000100;
    settle();
    for (int i = 0; i < LAT; i++) begin
      cyc(); settle();
      check("t3_bubble", {31'd0, bus.flush}, 32'd0);
    end
    cyc();
    bus.m_valid = 1'b1; bus.m_exc = 1'b1; bus.m_exccode = 5'd12;
    settle();
    check("t3_flush_acc", {31'd0, bus.flush}, 32'd1);
    bus.hw_int = '0; bus.m_exc = 1'b0;
    cyc(); settle();
    check("t3_enter", {31'd0, bus.cp0_enter}, 32'd1);
    check("t3_code",  {27'd0, bus.cp0_exccode}, 32'd0);
    wait_idle("t3_idle");
    $display("interrupt over exception priority checked");

    // Bubbles at M hold off a pending interrupt
    cyc();
    bus.m_valid = 1'b0; bus.hw_int = 6'b000100;
    settle();
    for (int i = 0; i < LAT + 3; i++) begin
      cyc(); settle();
      check("t4_bubble_flush", {31'd0, bus.flush}, 32'd0);
    end
    check("t4_pending", {26'd0, bus.ip_pending}, 32'h4);
    cyc();
    bus.m_valid = 1'b1;
    settle();
    check("t4_flush_acc", {31'd0, bus.flush}, 32'd1);
    bus.hw_int = '0;
    cyc(); settle();
    check("t4_enter", {31'd0, bus.cp0_enter}, 32'd1);
    wait_idle("t4_idle");
    $display("bubble hold-off checked");

    // EXL masks interrupts; ERET then exits
    cyc();
    bus.exl = 1'b1; bus.hw_int = 6'b000100; bus.m_valid = 1'b1;
    settle();
    for (int i = 0; i < LAT + 2; i++) begin
      cyc(); settle();
      check("t5_exl_mask", {31'd0, bus.flush}, 32'd0);
    end
    cyc();
    bus.m_eret = 1'b1; bus.epc = 32'h3040;
    settle();
    check("t5_flush_eret", {31'd0, bus.flush}, 32'd1);
    cyc();
    bus.m_eret = 1'b0;
    settle();
    check("t5_exl_clr", {31'd0, bus.cp0_exl_clr}, 32'd1);
    check("t5_rdpc",    bus.redirect_pc, 32'h3040);
    check("t5_redir",   {31'd0, bus.pc_redirect}, 32'd1);
    check("t5_noenter", {31'd0, bus.cp0_enter}, 32'd0);
    cyc(); settle();
    check("t5_clr_once", {31'd0, bus.cp0_exl_clr}, 32'd0);
    check("t5_busy",     {31'd0, bus.busy}, 32'd0);
    bus.hw_int = '0;
    repeat (LAT + 1) cyc();
    bus.exl = 1'b0;
    $display("EXL masking and ERET checked");

    // ERET together with an exception: exception wins
    cyc();
    bus.m_eret = 1'b1; bus.m_exc = 1'b1; bus.m_exccode = 5'd4;
    settle();
    check("t6_flush", {31'd0, bus.flush}, 32'd1);
    cyc();
    bus.m_eret = 1'b0; bus.m_exc = 1'b0;
    settle();
    check("t6_enter",  {31'd0, bus.cp0_enter}, 32'd1);
    check("t6_code",   {27'd0, bus.cp0_exccode}, 32'd4);
    check("t6_no_clr", {31'd0, bus.cp0_exl_clr}, 32'd0);
    wait_idle("t6_idle");
    $display("ERET versus exception checked");

    // Reset during DRAIN aborts cleanly
    cyc();
    bus.m_exc = 1'b1; bus.m_exccode = 5'd5; bus.m_pc = 32'h3100;
    cyc();
    bus.m_exc = 1'b0;
    settle();
    check("t7_enter", {31'd0, bus.cp0_enter}, 32'd1);
    check("t7_epc",   bus.cp0_epc, 32'h3100);
    cyc();
    reset = 1'b1;
    settle();
    check("t7_in_drain", {31'd0, bus.flush}, 32'd1);
    cyc(); settle();
    check("t7_busy",  {31'd0, bus.busy}, 32'd0);
    check("t7_flush", {31'd0, bus.flush}, 32'd0);
    check("t7_enter0", {31'd0, bus.cp0_enter}, 32'd0);
    check("t7_redir", {31'd0, bus.pc_redirect}, 32'd0);
    check("t7_code",  {27'd0, bus.cp0_exccode}, 32'd0);
    check("t7_epc0",  bus.cp0_epc, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      check("t7_no_enter", {31'd0, bus.cp0_enter}, 32'd0);
    end
    $display("reset abort checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
